// File: rtl/pla_seq_pkg.sv
// Shared constants and types for the PLA vector sequencer and its MISR.
package pla_seq_pkg;

    localparam int unsigned DEF_VEC_W = 24;
    localparam int unsigned DEF_SIG_W = 32;

    // MISR feedback polynomial (CRC-32 form, x^32 implicit).
    localparam logic [31:0] MISR_POLY = 32'h04C11DB7;

    // Fibonacci LFSR taps 24,23,22,17 -> vector bits 23,22,21,16.
    localparam logic [23:0] LFSR_TAP_MASK = 24'hE10000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pla_misr.sv
// Serial-input MISR: compacts one response bit per shift into the signature.
module pla_misr
    import pla_seq_pkg::*;
#(
    parameter int unsigned SIG_W = DEF_SIG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift,
    input  logic             bit_in,
    output logic [SIG_W-1:0] sig
);

    localparam logic [SIG_W-1:0] POLY = SIG_W'(MISR_POLY);

    logic [SIG_W-1:0] sig_next;

    // Shift left, fold in polynomial when the MSB falls out, inject bit_in at bit 0.
    always_comb begin
        sig_next = {sig[SIG_W-2:0], 1'b0}
                 ^ (sig[SIG_W-1] ? POLY : '0)
                 ^ {{(SIG_W-1){1'b0}}, bit_in};
    end

    // Signature register: cleared on run start, advanced once per captured bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clear) begin
            sig <= '0;
        end else if (shift) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/pla_vector_sequencer.sv
// Applies a run of input vectors (counter or LFSR) to a combinational
// function, one per clock, compacting its response into a MISR signature
// and counting ones.
module pla_vector_sequencer
    import pla_seq_pkg::*;
#(
    parameter int unsigned VEC_W = DEF_VEC_W,
    parameter int unsigned SIG_W = DEF_SIG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [VEC_W-1:0] seed,
    input  logic [VEC_W:0]   num_vec,
    output logic [VEC_W-1:0] x_vec,
    input  logic             y_in,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic [VEC_W:0]   ones_cnt
);

    localparam logic [VEC_W-1:0] TAPS = VEC_W'(LFSR_TAP_MASK);

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic             mode_q;
    logic [VEC_W:0]   remaining_q;
    logic             start_ok;
    logic             capture;
    logic             last_cap;
    logic [VEC_W-1:0] x_adv;
    logic [VEC_W-1:0] seed_load;

    // Qualify start, detect the final capture and form the next/initial vector.
    always_comb begin
        start_ok  = start && (state_q != ST_RUN);
        capture   = (state_q == ST_RUN);
        last_cap  = capture && (remaining_q == {{VEC_W{1'b0}}, 1'b1});
        if (mode_q) begin
            x_adv = {x_vec[VEC_W-2:0], ^(x_vec & TAPS)};
        end else begin
            x_adv = x_vec + {{(VEC_W-1){1'b0}}, 1'b1};
        end
        // An all-zero LFSR state would lock up, so it is replaced at load.
        if (mode && (seed == '0)) begin
            seed_load = {{(VEC_W-1){1'b0}}, 1'b1};
        end else begin
            seed_load = seed;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = (num_vec == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_cap) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Vector source, run length and ones counter; the final vector is held
    // rather than advanced so x_vec shows the last applied value in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_vec       <= '0;
            mode_q      <= 1'b0;
            remaining_q <= '0;
            ones_cnt    <= '0;
        end else if (start_ok) begin
            x_vec       <= seed_load;
            mode_q      <= mode;
            remaining_q <= num_vec;
            ones_cnt    <= '0;
        end else if (capture) begin
            ones_cnt    <= ones_cnt + {{VEC_W{1'b0}}, y_in};
            remaining_q <= remaining_q - {{VEC_W{1'b0}}, 1'b1};
            if (!last_cap) begin
                x_vec <= x_adv;
            end
        end
    end

    pla_misr #(
        .SIG_W (SIG_W)
    ) u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (start_ok),
        .shift  (capture),
        .bit_in (y_in),
        .sig    (signature)
    );

endmodule
